// File: rtl/cv32e40px_rvfi_retire_sched.sv
// Reorders retiring instructions so RVFI sees them in program order once late APU results land.
// Optional: define CV32E40PX_RVFI_SCHED_ORDER_EN to drive rvfi_order_o from a 64-bit retirement counter.
module cv32e40px_rvfi_retire_sched #(
    parameter int DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        retire_valid_i,
    input  logic        retire_pending_i,
    input  logic [31:0] retire_insn_i,
    input  logic [31:0] retire_pc_i,
    input  logic [4:0]  retire_rd_addr_i,
    input  logic [31:0] retire_rd_wdata_i,
    input  logic        apu_wb_valid_i,
    input  logic [31:0] apu_wb_data_i,
    output logic        retire_ready_o,
    output logic        rvfi_valid_o,
    output logic [31:0] rvfi_insn_o,
    output logic [31:0] rvfi_pc_rdata_o,
    output logic [4:0]  rvfi_rd_addr_o,
    output logic [31:0] rvfi_rd_wdata_o,
    output logic [63:0] rvfi_order_o,
    output logic        wb_err_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [31:0]      insn_q  [DEPTH];
    logic [31:0]      pc_q    [DEPTH];
    logic [31:0]      wdata_q [DEPTH];
    logic [4:0]       rd_q    [DEPTH];
    logic [DEPTH-1:0] pend_q;
    logic [AW-1:0]    head_q, tail_q;
    logic [AW:0]      count_q;

    logic          has_pend;
    logic [AW-1:0] wb_idx, scan_idx;
    logic          head_done, push, inc_done, bypass, pop, emit, store, wb_buf, wb_stray;
    logic [31:0]   inc_wdata;

    // Writebacks arrive in order, so they always target the oldest pending entry.
    always_comb begin
        has_pend = 1'b0;
        wb_idx   = head_q;
        scan_idx = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head_q + AW'(i);
            if (!has_pend && (i < int'(count_q)) && pend_q[scan_idx]) begin
                has_pend = 1'b1;
                wb_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        head_done      = (count_q != '0) && (!pend_q[head_q] || apu_wb_valid_i);
        retire_ready_o = (count_q < FULL) || head_done;
        push           = retire_valid_i && retire_ready_o;
        inc_done       = !retire_pending_i || (apu_wb_valid_i && !has_pend);
        inc_wdata      = retire_pending_i ? apu_wb_data_i : retire_rd_wdata_i;
        bypass         = (count_q == '0) && push && inc_done;
        pop            = head_done;
        emit           = pop || bypass;
        store          = push && !bypass;
        wb_buf         = apu_wb_valid_i && has_pend;
        wb_stray       = apu_wb_valid_i && !has_pend && !(push && retire_pending_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            pend_q          <= '0;
            wb_err_o        <= 1'b0;
            rvfi_valid_o    <= 1'b0;
            rvfi_insn_o     <= '0;
            rvfi_pc_rdata_o <= '0;
            rvfi_rd_addr_o  <= '0;
            rvfi_rd_wdata_o <= '0;
        end else begin
            if (pop)   head_q <= head_q + AW'(1);
            if (store) tail_q <= tail_q + AW'(1);
            count_q <= count_q + (AW+1)'(store) - (AW+1)'(pop);
            if (wb_buf)   pend_q[wb_idx] <= 1'b0;
            // A full-buffer push reuses the slot being popped, so it must win.
            if (store)    pend_q[tail_q] <= !inc_done;
            if (wb_stray) wb_err_o <= 1'b1;
            rvfi_valid_o <= emit;
            if (bypass) begin
                rvfi_insn_o     <= retire_insn_i;
                rvfi_pc_rdata_o <= retire_pc_i;
                rvfi_rd_addr_o  <= retire_rd_addr_i;
                rvfi_rd_wdata_o <= inc_wdata;
            end else if (pop) begin
                rvfi_insn_o     <= insn_q[head_q];
                rvfi_pc_rdata_o <= pc_q[head_q];
                rvfi_rd_addr_o  <= rd_q[head_q];
                rvfi_rd_wdata_o <= pend_q[head_q] ? apu_wb_data_i : wdata_q[head_q];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (wb_buf) wdata_q[wb_idx] <= apu_wb_data_i;
        if (store) begin
            insn_q[tail_q]  <= retire_insn_i;
            pc_q[tail_q]    <= retire_pc_i;
            rd_q[tail_q]    <= retire_rd_addr_i;
            wdata_q[tail_q] <= inc_wdata;
        end
    end

`ifdef CV32E40PX_RVFI_SCHED_ORDER_EN
    logic [63:0] order_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            order_q      <= '0;
            rvfi_order_o <= '0;
        end else if (emit) begin
            rvfi_order_o <= order_q;
            order_q      <= order_q + 64'd1;
        end
    end
`else
    assign rvfi_order_o = '0;
`endif

endmodule

// File: tb/tb_cv32e40px_rvfi_retire_sched.sv
// Bench: queue-based model of the retire scheduler, directed scenarios then random traffic.
module tb_cv32e40px_rvfi_retire_sched;
    localparam int D = 4;

    logic        clk_i = 1'b0, rst_ni = 1'b1;
    logic        retire_valid_i = 1'b0, retire_pending_i = 1'b0;
    logic [31:0] retire_insn_i = '0, retire_pc_i = '0, retire_rd_wdata_i = '0;
    logic [4:0]  retire_rd_addr_i = '0;
    logic        apu_wb_valid_i = 1'b0;
    logic [31:0] apu_wb_data_i = '0;
    logic        retire_ready_o, rvfi_valid_o, wb_err_o;
    logic [31:0] rvfi_insn_o, rvfi_pc_rdata_o, rvfi_rd_wdata_o;
    logic [4:0]  rvfi_rd_addr_o;
    logic [63:0] rvfi_order_o;

    cv32e40px_rvfi_retire_sched #(.DEPTH(D)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .retire_valid_i(retire_valid_i), .retire_pending_i(retire_pending_i),
        .retire_insn_i(retire_insn_i), .retire_pc_i(retire_pc_i),
        .retire_rd_addr_i(retire_rd_addr_i), .retire_rd_wdata_i(retire_rd_wdata_i),
        .apu_wb_valid_i(apu_wb_valid_i), .apu_wb_data_i(apu_wb_data_i),
        .retire_ready_o(retire_ready_o), .rvfi_valid_o(rvfi_valid_o),
        .rvfi_insn_o(rvfi_insn_o), .rvfi_pc_rdata_o(rvfi_pc_rdata_o),
        .rvfi_rd_addr_o(rvfi_rd_addr_o), .rvfi_rd_wdata_o(rvfi_rd_wdata_o),
        .rvfi_order_o(rvfi_order_o), .wb_err_o(wb_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] insn, pc, wdata;
        logic [4:0]  rd;
        logic        pend;
    } ent_t;

    ent_t        q[$];
    logic        m_err, e_vld;
    ent_t        e_ent;
    logic [63:0] e_order, m_cnt;
    int          n_tests = 0, n_fail = 0;

    task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", n, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_err = 1'b0; e_vld = 1'b0; e_order = '0; m_cnt = '0;
        e_ent = '{insn: '0, pc: '0, wdata: '0, rd: '0, pend: 1'b0};
    endtask

    // One clock cycle: drive, compare at negedge, then advance the model across the edge.
    task automatic cyc(input logic v, input logic p, input logic [31:0] insn, input logic [31:0] pc,
                       input logic [4:0] rd, input logic [31:0] wd, input logic wb, input logic [31:0] wbd);
        logic rdy, acc;
        int   idx;
        ent_t inc;
        retire_valid_i = v; retire_pending_i = p; retire_insn_i = insn; retire_pc_i = pc;
        retire_rd_addr_i = rd; retire_rd_wdata_i = wd; apu_wb_valid_i = wb; apu_wb_data_i = wbd;
        @(negedge clk_i);
        rdy = (q.size() < D) || !q[0].pend || wb;
        chk("ready", retire_ready_o, rdy);
        chk("valid", rvfi_valid_o, e_vld);
        chk("insn",  rvfi_insn_o, e_ent.insn);
        chk("pc",    rvfi_pc_rdata_o, e_ent.pc);
        chk("rd",    rvfi_rd_addr_o, e_ent.rd);
        chk("wdata", rvfi_rd_wdata_o, e_ent.wdata);
        chk("order", rvfi_order_o, e_order);
        chk("wb_err", wb_err_o, m_err);
        acc = v && rdy;
        inc = '{insn: insn, pc: pc, wdata: wd, rd: rd, pend: p};
        idx = -1;
        foreach (q[i]) if (idx < 0 && q[i].pend) idx = i;
        if (wb) begin
            if (idx >= 0) begin q[idx].wdata = wbd; q[idx].pend = 1'b0; end
            else if (acc && p) begin inc.wdata = wbd; inc.pend = 1'b0; end
            else m_err = 1'b1;
        end
        if (acc) q.push_back(inc);
        e_vld = 1'b0;
        if (q.size() > 0 && !q[0].pend) begin
            e_ent = q.pop_front();
            e_vld = 1'b1;
`ifdef CV32E40PX_RVFI_SCHED_ORDER_EN
            e_order = m_cnt;
`endif
            m_cnt = m_cnt + 64'd1;
        end
        @(posedge clk_i); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        retire_valid_i = 1'b0; apu_wb_valid_i = 1'b0;
        #1;
        chk("rst_valid", rvfi_valid_o, 0);
        chk("rst_ready", retire_ready_o, 1);
        chk("rst_err",   wb_err_o, 0);
        chk("rst_pc",    rvfi_pc_rdata_o, 0);
        chk("rst_order", rvfi_order_o, 0);
        model_clear();
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
    endtask

    initial begin
        model_clear();
        #2;
        do_reset();

        // single complete retire bypasses the empty buffer
        cyc(1, 0, 32'h00a00093, 32'h80, 5'd1, 32'd10, 0, 0);
        chk("t33_valid", rvfi_valid_o, 1);
        chk("t33_pc",    rvfi_pc_rdata_o, 32'h80);
        chk("t33_rd",    rvfi_rd_addr_o, 5'd1);
        chk("t33_wdata", rvfi_rd_wdata_o, 32'd10);
        chk("t33_order", rvfi_order_o, 0);
        idle(1);
        chk("t33_hold_pc", rvfi_pc_rdata_o, 32'h80);

        // pending head blocks younger complete entries
        cyc(1, 1, 32'h1, 32'h100, 5'd5, 0, 0, 0);
        cyc(1, 0, 32'h2, 32'h104, 5'd6, 32'd6, 0, 0);
        cyc(1, 0, 32'h3, 32'h108, 5'd7, 32'd7, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 32'h3f800000);
        chk("t34_a_pc",    rvfi_pc_rdata_o, 32'h100);
        chk("t34_a_wdata", rvfi_rd_wdata_o, 32'h3f800000);
        idle(1);
        chk("t34_b_pc", rvfi_pc_rdata_o, 32'h104);
        idle(1);
        chk("t34_c_pc", rvfi_pc_rdata_o, 32'h108);
        chk("t34_c_valid", rvfi_valid_o, 1);
        idle(1);

        // full buffer with pending head
        do_reset();
        cyc(1, 1, 32'h10, 32'h200, 5'd2, 0, 0, 0);
        for (int i = 1; i < 4; i++) cyc(1, 0, 32'h10 + i, 32'h200 + 4*i, 5'd3, i, 0, 0);
        retire_valid_i = 1'b1; apu_wb_valid_i = 1'b0;
        #1 chk("t35_full_ready", retire_ready_o, 0);
        apu_wb_valid_i = 1'b1;
        #1 chk("t35_wb_ready", retire_ready_o, 1);
        cyc(1, 0, 32'h14, 32'h210, 5'd4, 32'd44, 1, 32'hcafe);
        chk("t35_first_wdata", rvfi_rd_wdata_o, 32'hcafe);
        idle(5);

        // stray writeback
        do_reset();
        cyc(0, 0, 0, 0, 0, 0, 1, 32'h5);
        chk("t36_err", wb_err_o, 1);
        chk("t36_novalid", rvfi_valid_o, 0);
        idle(3);

        // pending retire completed in the same cycle
        do_reset();
        cyc(1, 1, 32'h20, 32'h300, 5'd8, 0, 1, 32'h1234);
        chk("t37_valid", rvfi_valid_o, 1);
        chk("t37_wdata", rvfi_rd_wdata_o, 32'h1234);
        idle(1);

        // reset discards buffered entries
        cyc(1, 1, 32'h30, 32'h400, 5'd9, 0, 0, 0);
        cyc(1, 0, 32'h31, 32'h404, 5'd9, 1, 0, 0);
        cyc(1, 0, 32'h32, 32'h408, 5'd9, 2, 0, 0);
        do_reset();
        idle(2);
        cyc(1, 0, 32'h40, 32'h500, 5'd1, 32'd77, 0, 0);
        chk("t38_valid", rvfi_valid_o, 1);
        chk("t38_order", rvfi_order_o, 0);
        chk("t38_pc",    rvfi_pc_rdata_o, 32'h500);

        // random traffic
        do_reset();
        for (int k = 0; k < 800; k++) begin
            int   np;
            logic v, p, wb;
            np = 0;
            foreach (q[i]) if (q[i].pend) np++;
            v  = ($urandom % 4) != 0;
            p  = ($urandom % 3) == 0;
            wb = (np > 0) ? (($urandom % 5) < 2) : (($urandom % 60) == 0);
            if (k == 400) do_reset();
            cyc(v, p, $urandom, $urandom, 5'($urandom), $urandom, wb, $urandom);
        end
        idle(8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
